// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - MIPS instruction-fetch sequencer: PC, IF/ID register, stall/redirect/halt control
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd4,
    parameter logic [31:0] LAST_PC  = 32'd28,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc4_o,
    output logic             ifid_valid_o,
    output logic             halted_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0]      redirect_pc;
    logic             redirect_beyond;
    logic             redirect_unaligned;
    logic [31:0]      pc_plus4;
    logic [CNT_W-1:0] count_inc;

    // Low address bits of a redirect are dropped; the fact they were set is reported via misalign.
    assign redirect_pc        = {branch_target_i[31:2], 2'b00};
    assign redirect_beyond    = redirect_pc > LAST_PC;
    assign redirect_unaligned = branch_target_i[1:0] != 2'b00;
    assign pc_plus4           = pc_q + 32'd4;
    assign count_inc          = (&count_q) ? count_q : count_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        misalign_d = misalign_q;
        count_d    = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (branch_taken_i) begin
                    pc_d    = redirect_pc;
                    instr_d = 32'd0;
                    pc4_d   = 32'd0;
                    valid_d = 1'b0;
                    if (redirect_unaligned) begin
                        misalign_d = 1'b1;
                    end
                    if (redirect_beyond) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                end else if (stall_i) begin
                    // Hold everything: the decode stage keeps its current instruction.
                end else if (pc_q > LAST_PC) begin
                    instr_d  = 32'd0;
                    pc4_d    = 32'd0;
                    valid_d  = 1'b0;
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    instr_d = imem_data_i;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    count_d = count_inc;
                end
            end

            S_HALT: begin
                instr_d = 32'd0;
                pc4_d   = 32'd0;
                valid_d = 1'b0;
                if (branch_taken_i) begin
                    pc_d = redirect_pc;
                    if (redirect_unaligned) begin
                        misalign_d = 1'b1;
                    end
                    if (!redirect_beyond) begin
                        state_d  = S_RUN;
                        halted_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            pc4_q      <= 32'd0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign ifid_instr_o  = instr_q;
    assign ifid_pc4_o    = pc4_q;
    assign ifid_valid_o  = valid_q;
    assign halted_o      = halted_q;
    assign misalign_o    = misalign_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer with directed plan and random reference-model run
module tb_fetch_sequencer;

    localparam int          CNT_W = 16;
    localparam logic [31:0] RST_PC = 32'd4;
    localparam logic [31:0] LAST  = 32'd28;

    logic             clk = 1'b0;
    logic             rst, start, stall, branch_taken;
    logic [31:0]      branch_target;
    logic [31:0]      imem_addr, imem_data;
    logic [31:0]      ifid_instr, ifid_pc4;
    logic             ifid_valid, halted, misalign;
    logic [CNT_W-1:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:63];

    // Reference state, stepped once per clock from the behavioural rules.
    int          m_mode;  // 0 idle, 1 running, 2 stopped
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted, m_mis;
    int          m_cnt;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(RST_PC), .LAST_PC(LAST), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
        .branch_taken_i(branch_taken), .branch_target_i(branch_target),
        .imem_addr_o(imem_addr), .imem_data_i(imem_data),
        .ifid_instr_o(ifid_instr), .ifid_pc4_o(ifid_pc4), .ifid_valid_o(ifid_valid),
        .halted_o(halted), .misalign_o(misalign), .fetch_count_o(fetch_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd256) return mem[a[7:2]];
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = RST_PC; m_instr = 0; m_pc4 = 0;
        m_valid = 0; m_halted = 0; m_mis = 0; m_cnt = 0;
    endtask

    task automatic model_bubble();
        m_instr = 0; m_pc4 = 0; m_valid = 0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        tgt = branch_target & 32'hFFFF_FFFC;
        if (rst) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (branch_taken) begin
                if (branch_target % 4 != 0) m_mis = 1;
                m_pc = tgt;
                model_bubble();
                if (tgt > LAST) begin m_mode = 2; m_halted = 1; end
            end else if (stall) begin
            end else if (m_pc > LAST) begin
                model_bubble();
                m_mode = 2; m_halted = 1;
            end else begin
                m_instr = mem_word(m_pc);
                m_pc4 = m_pc + 4;
                m_valid = 1;
                m_pc = m_pc + 4;
                if (m_cnt < 65535) m_cnt++;
            end
        end else begin
            model_bubble();
            if (branch_taken) begin
                if (branch_target % 4 != 0) m_mis = 1;
                m_pc = tgt;
                if (tgt <= LAST) begin m_mode = 1; m_halted = 0; end
            end
        end
    endtask

    task automatic compare_model();
        check("m_addr",  imem_addr, m_pc);
        check("m_instr", ifid_instr, m_instr);
        check("m_pc4",   ifid_pc4, m_pc4);
        check("m_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
        check("m_halt",  {31'd0, halted}, {31'd0, m_halted});
        check("m_mis",   {31'd0, misalign}, {31'd0, m_mis});
        check("m_cnt",   {16'd0, fetch_count}, m_cnt[31:0]);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic drive(input logic r, input logic s, input logic st, input logic b, input logic [31:0] t);
        rst = r; start = s; stall = st; branch_taken = b; branch_target = t;
    endtask

    task automatic restart();
        drive(1, 0, 0, 0, 0); step(); step();
        drive(0, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);
    endtask

    logic [31:0] prog [0:4];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[1] = 32'h00231022; mem[2] = 32'h00456024; mem[3] = 32'h00C26825;
        mem[4] = 32'h00427020; mem[5] = 32'hAC4F0064;
        for (int i = 0; i < 5; i++) prog[i] = mem[i+1];
        model_reset();

        // Reset state
        drive(1, 0, 0, 0, 0);
        step(); step();
        check("rst_pc", imem_addr, 32'd4);
        check("rst_instr", ifid_instr, 32'd0);
        check("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_cnt", {16'd0, fetch_count}, 32'd0);

        // Straight-line run
        drive(0, 1, 0, 0, 0); step();
        check("idle_no_fetch", {31'd0, ifid_valid}, 32'd0);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("run_instr", ifid_instr, prog[i]);
            check("run_pc4", ifid_pc4, 32'd8 + 32'(4 * i));
        end
        check("run_cnt", {16'd0, fetch_count}, 32'd5);

        // Stall hold at pc=12
        restart();
        step(); step();
        check("pre_stall_pc", imem_addr, 32'd12);
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_instr", ifid_instr, 32'h00456024);
            check("stall_pc", imem_addr, 32'd12);
            check("stall_cnt", {16'd0, fetch_count}, 32'd2);
        end
        drive(0, 0, 0, 0, 0); step();
        check("post_stall", ifid_instr, 32'h00C26825);

        // Redirect with simultaneous stall at pc=16
        drive(0, 0, 1, 1, 32'd8); step();
        check("br_pc", imem_addr, 32'd8);
        check("br_valid", {31'd0, ifid_valid}, 32'd0);
        check("br_instr", ifid_instr, 32'd0);
        check("br_cnt", {16'd0, fetch_count}, 32'd3);
        drive(0, 0, 0, 0, 0); step();
        check("br_refetch", ifid_instr, 32'h00456024);

        // End of program
        while (imem_addr != 32'd32 && n_checks < 100000) step();
        check("end_pc", imem_addr, 32'd32);
        step();
        check("end_halt", {31'd0, halted}, 32'd1);
        check("end_valid", {31'd0, ifid_valid}, 32'd0);
        check("end_pc_hold", imem_addr, 32'd32);
        drive(0, 1, 1, 0, 0); step();
        check("halt_hold", imem_addr, 32'd32);
        drive(0, 0, 0, 1, 32'd4); step();
        check("unhalt", {31'd0, halted}, 32'd0);
        drive(0, 0, 0, 0, 0); step();
        check("refetch4", ifid_instr, 32'h00231022);

        // Misaligned redirect
        drive(0, 0, 0, 1, 32'h0000000E); step();
        check("mis_pc", imem_addr, 32'd12);
        check("mis_flag", {31'd0, misalign}, 32'd1);
        drive(0, 0, 0, 1, 32'd8); step();
        check("mis_sticky", {31'd0, misalign}, 32'd1);
        drive(0, 0, 0, 1, 32'd40); step();
        check("br_beyond_halt", {31'd0, halted}, 32'd1);
        check("br_beyond_pc", imem_addr, 32'd40);
        drive(0, 0, 0, 1, 32'd44); step();
        check("halt_br_beyond", imem_addr, 32'd44);

        // Reset mid-stall
        restart();
        step(); step();
        drive(1, 0, 1, 0, 0); step();
        check("rst2_pc", imem_addr, 32'd4);
        check("rst2_instr", ifid_instr, 32'd0);
        check("rst2_pc4", ifid_pc4, 32'd0);
        check("rst2_cnt", {16'd0, fetch_count}, 32'd0);
        check("rst2_mis", {31'd0, misalign}, 32'd0);
        drive(0, 0, 0, 1, 32'd16); step();
        drive(0, 0, 1, 0, 0); step();
        check("idle_ignore_pc", imem_addr, 32'd4);
        check("idle_ignore_cnt", {16'd0, fetch_count}, 32'd0);

        // Randomised run against the reference model
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  (r < 7) ? 32'($urandom_range(0, 40)) :
                  (r < 9) ? 32'($urandom_range(0, 63) * 4) : $urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
